// File: rtl/debug_mem_walker.sv
// Debug memory walker: streams words into (fill) or out of (dump) a memory
// debug port, one word per cycle, with a 2-entry read buffer on the dump side.
module debug_mem_walker #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [29:0]      cmd_base,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [29:0]      debug_addr,
  output logic [3:0]       debug_write_en,
  output logic [31:0]      debug_in_data,
  input  logic [31:0]      debug_out_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FILL_LAST,
    S_DUMP,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [29:0]      base_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_inc;
  logic             has_rem;
  logic             accept;
  logic             first_rd;
  logic             wr_fire;
  logic             issue_rd;
  logic             pop;
  logic             push;
  logic             in_flight;
  logic [29:0]      issue_addr;
  logic             issue_high;
  logic [1:0]       occ;
  logic [2:0]       pending;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [31:0]      fifo0;
  logic [31:0]      fifo1;

  assign idx_inc    = idx_q + ONE;
  assign has_rem    = (idx_q != count_q);
  assign issue_addr = base_q + 30'(idx_q);
  assign issue_high = |issue_addr[29:12];

  // The first dump read goes out on the accept edge so data can surface two cycles later.
  assign first_rd   = accept & ~cmd_write & (cmd_count != '0);

  assign rd_valid   = (occ != 2'd0);
  assign rd_data    = rd_ptr ? fifo1 : fifo0;
  assign pop        = rd_valid & rd_ready;
  assign push       = in_flight;

  // Slots that will be committed after this edge; counting the pop keeps 1 word/cycle.
  assign pending    = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};

  // Next-state and handshake decode for the transfer sequencer.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    accept     = 1'b0;
    wr_fire    = 1'b0;
    issue_rd   = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_count == '0) begin
            state_next = S_DONE;
          end else if (cmd_write) begin
            state_next = S_FILL;
          end else begin
            state_next = S_DUMP;
          end
        end
      end
      S_FILL: begin
        wr_ready = has_rem;
        wr_fire  = wr_valid & has_rem;
        if (wr_fire && (idx_inc == count_q)) begin
          state_next = S_FILL_LAST;
        end
      end
      S_FILL_LAST: begin
        state_next = S_DONE;
      end
      S_DUMP: begin
        issue_rd = has_rem && (pending < 3'd2);
        if (!has_rem && (pending == 3'd0)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Command latch, word index, registered memory port and sticky range flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q         <= '0;
      count_q        <= '0;
      idx_q          <= '0;
      in_flight      <= 1'b0;
      err            <= 1'b0;
      debug_addr     <= '0;
      debug_in_data  <= '0;
      debug_write_en <= 4'h0;
    end else begin
      debug_write_en <= 4'h0;
      in_flight      <= first_rd | issue_rd;
      if (accept) begin
        base_q  <= cmd_base;
        count_q <= cmd_count;
        if (first_rd) begin
          idx_q      <= ONE;
          debug_addr <= cmd_base;
          err        <= |cmd_base[29:12];
        end else begin
          idx_q <= '0;
          err   <= 1'b0;
        end
      end else if (wr_fire) begin
        idx_q          <= idx_inc;
        debug_addr     <= issue_addr;
        debug_in_data  <= wr_data;
        debug_write_en <= 4'hF;
        err            <= err | issue_high;
      end else if (issue_rd) begin
        idx_q      <= idx_inc;
        debug_addr <= issue_addr;
        err        <= err | issue_high;
      end
    end
  end

  // Two-entry read buffer; capture and pop may happen on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo0  <= '0;
      fifo1  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) begin
          fifo1 <= debug_out_data;
        end else begin
          fifo0 <= debug_out_data;
        end
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_debug_mem_walker.sv
// Directed self-checking bench for debug_mem_walker with a small memory model.
module tb_debug_mem_walker;

  localparam int CNT_W = 13;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [29:0]      cmd_base;
  logic [CNT_W-1:0] cmd_count;
  logic [31:0]      wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [29:0]      debug_addr;
  logic [3:0]       debug_write_en;
  logic [31:0]      debug_in_data;
  logic [31:0]      debug_out_data;
  logic             busy;
  logic             done;
  logic             err;

  logic [31:0]      mem [16];
  logic             load_en;
  logic [3:0]       load_addr;
  logic [31:0]      load_data;

  int n_cmp;
  int n_fail;

  debug_mem_walker #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_base      (cmd_base),
    .cmd_count     (cmd_count),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .debug_addr    (debug_addr),
    .debug_write_en(debug_write_en),
    .debug_in_data (debug_in_data),
    .debug_out_data(debug_out_data),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data for the presented address is available by the next edge.
  assign debug_out_data = mem[debug_addr[3:0]];

  // Memory writes from the DUT, plus a bench-side preload port.
  always @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (debug_write_en == 4'hF) begin
      mem[debug_addr[3:0]] <= debug_in_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic send_cmd(input logic w, input logic [29:0] b, input logic [CNT_W-1:0] c);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_base  = b;
    cmd_count = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    n_cmp++; if ({wr_ready, rd_valid, busy, done, err} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 00000", {wr_ready, rd_valid, busy, done, err}); end
    n_cmp++; if (rd_data !== 32'h0 || debug_in_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_data: got %h/%h expected 0/0", rd_data, debug_in_data); end
    n_cmp++; if (debug_addr !== 30'h0 || debug_write_en !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_port: got %h/%h expected 0/0", debug_addr, debug_write_en); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    send_cmd(1'b1, 30'h0, 13'd3);
    n_cmp++; if (busy !== 1'b1 || wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_start: got busy=%b wr_ready=%b expected 1/1", busy, wr_ready); end
    wr_valid = 1'b1;
    wr_data  = 32'h11;
    tick();
    n_cmp++; if (debug_write_en !== 4'hF || debug_addr !== 30'd0 || debug_in_data !== 32'h11) begin n_fail++; $display("[TB] FAIL fill_w0: got we=%h a=%h d=%h expected F/0/11", debug_write_en, debug_addr, debug_in_data); end
    wr_data = 32'h22;
    tick();
    n_cmp++; if (debug_write_en !== 4'hF || debug_addr !== 30'd1 || debug_in_data !== 32'h22) begin n_fail++; $display("[TB] FAIL fill_w1: got we=%h a=%h d=%h expected F/1/22", debug_write_en, debug_addr, debug_in_data); end
    wr_data = 32'h33;
    tick();
    n_cmp++; if (debug_write_en !== 4'hF || debug_addr !== 30'd2 || debug_in_data !== 32'h33) begin n_fail++; $display("[TB] FAIL fill_w2: got we=%h a=%h d=%h expected F/2/33", debug_write_en, debug_addr, debug_in_data); end
    n_cmp++; if (wr_ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_last: got wr_ready=%b done=%b expected 0/0", wr_ready, done); end
    wr_valid = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b1 || debug_write_en !== 4'h0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_done: got done=%b we=%h err=%b expected 1/0/0", done, debug_write_en, err); end
    n_cmp++; if (mem[0] !== 32'h11 || mem[1] !== 32'h22 || mem[2] !== 32'h33) begin n_fail++; $display("[TB] FAIL fill_mem: got %h %h %h expected 11 22 33", mem[0], mem[1], mem[2]); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_idle: got done=%b busy=%b ready=%b expected 0/0/1", done, busy, cmd_ready); end
  endtask

  task automatic test_dump();
    logic [31:0] exp_words [4];
    exp_words = '{32'h9, 32'hB, 32'h3, 32'h0};
    load_word(4'd0, 32'h9);
    load_word(4'd1, 32'hB);
    load_word(4'd2, 32'h3);
    load_word(4'd3, 32'h0);
    rd_ready = 1'b1;
    send_cmd(1'b0, 30'h0, 13'd4);
    n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dump_early: got rd_valid=%b expected 0", rd_valid); end
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_words[k]) begin n_fail++; $display("[TB] FAIL dump_word%0d: got v=%b d=%h expected 1/%h", k, rd_valid, rd_data, exp_words[k]); end
      tick();
    end
    n_cmp++; if (rd_valid !== 1'b0 || done !== 1'b1) begin n_fail++; $display("[TB] FAIL dump_done: got v=%b done=%b expected 0/1", rd_valid, done); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL dump_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_dump_stall();
    logic [31:0] exp_words [4];
    int          pat [4];
    int          n;
    int          outstanding;
    logic        stalled;
    logic        seen_done;
    logic [31:0] held;
    exp_words = '{32'h9, 32'hB, 32'h3, 32'h0};
    pat       = '{1, 0, 0, 1};
    n         = 0;
    stalled   = 1'b0;
    seen_done = 1'b0;
    held      = 32'h0;
    rd_ready  = 1'b0;
    send_cmd(1'b0, 30'h0, 13'd4);
    for (int k = 0; k < 40 && !seen_done; k++) begin
      rd_ready = (pat[k % 4] != 0);
      if (stalled) begin
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== held) begin n_fail++; $display("[TB] FAIL stall_hold: got v=%b d=%h expected 1/%h", rd_valid, rd_data, held); end
      end
      if (busy) begin
        outstanding = int'(debug_addr) + 1 - n;
        n_cmp++; if (outstanding > 2) begin n_fail++; $display("[TB] FAIL stall_outstanding: got %0d expected <=2", outstanding); end
      end
      if (done) begin
        seen_done = 1'b1;
        n_cmp++; if (n != 4) begin n_fail++; $display("[TB] FAIL stall_count: got %0d words expected 4", n); end
      end
      if (rd_valid && rd_ready) begin
        n_cmp++;
        if (n >= 4) begin
          n_fail++; $display("[TB] FAIL stall_extra: got word %h expected none", rd_data);
        end else if (rd_data !== exp_words[n]) begin
          n_fail++; $display("[TB] FAIL stall_word%0d: got %h expected %h", n, rd_data, exp_words[n]);
        end
        n++;
      end
      stalled = rd_valid && !rd_ready;
      held    = rd_data;
      tick();
    end
    n_cmp++; if (!seen_done) begin n_fail++; $display("[TB] FAIL stall_timeout: got no done expected done within 40 cycles"); end
    rd_ready = 1'b1;
    tick();
  endtask

  task automatic test_zero_count();
    send_cmd(1'b0, 30'h5, 13'd0);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_done: got done=%b busy=%b expected 1/1", done, busy); end
    n_cmp++; if (debug_write_en !== 4'h0 || debug_addr !== 30'd3 || rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_noaccess: got we=%h a=%h v=%b expected 0/3/0", debug_write_en, debug_addr, rd_valid); end
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || debug_addr !== 30'd3) begin n_fail++; $display("[TB] FAIL zero_idle: got busy=%b done=%b a=%h expected 0/0/3", busy, done, debug_addr); end
  endtask

  task automatic test_err_range();
    load_word(4'hF, 32'hAA);
    load_word(4'h0, 32'h55);
    rd_ready = 1'b1;
    send_cmd(1'b0, 30'h3FFF, 13'd2);
    n_cmp++; if (debug_addr !== 30'h3FFF) begin n_fail++; $display("[TB] FAIL err_addr0: got %h expected 3fff", debug_addr); end
    tick();
    n_cmp++; if (debug_addr !== 30'h4000 || rd_valid !== 1'b1 || rd_data !== 32'hAA) begin n_fail++; $display("[TB] FAIL err_word0: got a=%h v=%b d=%h expected 4000/1/aa", debug_addr, rd_valid, rd_data); end
    tick();
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 32'h55) begin n_fail++; $display("[TB] FAIL err_word1: got v=%b d=%h expected 1/55", rd_valid, rd_data); end
    tick();
    n_cmp++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_at_done: got done=%b err=%b expected 1/1", done, err); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_wrap_fill();
    wr_valid = 1'b1;
    wr_data  = 32'h5A;
    send_cmd(1'b1, 30'h3FFFFFFF, 13'd2);
    n_cmp++; if (err !== 1'b0 || wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_clear: got err=%b wr_ready=%b expected 0/1", err, wr_ready); end
    tick();
    n_cmp++; if (debug_addr !== 30'h3FFFFFFF || debug_write_en !== 4'hF || err !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_w0: got a=%h we=%h err=%b expected 3fffffff/F/1", debug_addr, debug_write_en, err); end
    wr_data = 32'hA5;
    tick();
    n_cmp++; if (debug_addr !== 30'h0 || debug_in_data !== 32'hA5 || debug_write_en !== 4'hF) begin n_fail++; $display("[TB] FAIL wrap_w1: got a=%h d=%h we=%h expected 0/a5/F", debug_addr, debug_in_data, debug_write_en); end
    wr_valid = 1'b0;
    tick();
    n_cmp++; if (done !== 1'b1 || mem[15] !== 32'h5A || mem[0] !== 32'hA5) begin n_fail++; $display("[TB] FAIL wrap_done: got done=%b m15=%h m0=%h expected 1/5a/a5", done, mem[15], mem[0]); end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    load_word(4'd3, 32'hDEAD);
    send_cmd(1'b1, 30'h0, 13'd8);
    wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_data = 32'h100 + k;
      tick();
    end
    wr_data = 32'h103;
    n_cmp++; if (debug_write_en !== 4'hF || debug_addr !== 30'd2) begin n_fail++; $display("[TB] FAIL rst_third_write: got we=%h a=%h expected F/2", debug_write_en, debug_addr); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (debug_write_en !== 4'h0 || cmd_ready !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_immediate: got we=%h ready=%b busy=%b wr_ready=%b expected 0/1/0/0", debug_write_en, cmd_ready, busy, wr_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (debug_write_en !== 4'h0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_after%0d: got we=%h ready=%b busy=%b expected 0/1/0", k, debug_write_en, cmd_ready, busy); end
    end
    n_cmp++; if (mem[3] !== 32'hDEAD) begin n_fail++; $display("[TB] FAIL rst_no_write: got %h expected dead", mem[3]); end
    wr_valid = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_base  = '0;
    cmd_count = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h0;
    end
    test_reset();
    test_fill();
    test_dump();
    test_dump_stall();
    test_zero_count();
    test_err_range();
    test_wrap_fill();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
